data_bus_responder: RTL and testbench

Responder end of the core's data-memory port. It services `ram_r` / `ram_w` / `ram_addr` / `ram_out` requests from the single-cycle core:
- returns read data on `ram_in` in the same cycle;
- commits writes on the clock edge.

It decodes the address into a byte-enabled data RAM and an MMIO page. The MMIO page holds a console transmit FIFO (drained over a valid/ready byte stream), a free-running cycle counter, and a halt latch driven by the core's `brk`.

---
 rtl/data_bus_responder_if.sv | 35 +++
 rtl/data_bus_responder.sv | 156 +++++++++++++++
 tb/tb_data_bus_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_responder_if
// Description : Core data-memory port plus the console TX byte stream.
//               master = core / stream sink side, slave = responder side.
// Revision    : 1.0  initial release
// ============================================================================
interface data_bus_responder_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic               ram_r;
    logic [3:0]         ram_w;
    logic [31:0]        ram_addr;
    logic [31:0]        ram_out;
    logic [31:0]        ram_in;
    logic               brk;
    logic               halted;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [c_LVL_W-1:0] fifo_level;

    modport master (
        output ram_r, ram_w, ram_addr, ram_out, brk, tx_ready,
        input  ram_in, halted, tx_data, tx_valid, fifo_level
    );

    modport slave (
        input  ram_r, ram_w, ram_addr, ram_out, brk, tx_ready,
        output ram_in, halted, tx_data, tx_valid, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_responder
// Description : Responder for the core's data port: byte-enabled data RAM
//               with zero-latency reads, plus an MMIO page holding a console
//               TX FIFO, a free-running cycle counter and a halt latch.
// Revision    : 1.0  initial release
// ============================================================================
module data_bus_responder #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    data_bus_responder_if.slave  bus
);
    localparam int c_AW  = $clog2(RAM_WORDS);
    localparam int c_PW  = $clog2(FIFO_DEPTH);
    localparam int c_LW  = c_PW + 1;
    localparam logic [29:0]     c_TXDATA_WORD = 30'h2000_0000;
    localparam logic [29:0]     c_STATUS_WORD = 30'h2000_0001;
    localparam logic [29:0]     c_CYCLE_WORD  = 30'h2000_0002;
    localparam logic [c_LW-1:0] c_FULL_LEVEL  = c_LW'(FIFO_DEPTH);

    // Registered state
    logic            r_halted;
    logic [31:0]     r_cycle;
    logic            r_ovf;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic [7:0]      r_fifo [FIFO_DEPTH];

    // Decode and control
    logic [29:0]     w_word;
    logic            w_ram_hit;
    logic [c_AW-1:0] w_ram_idx;
    logic [3:0]      w_ram_we;
    logic [31:0]     w_ram_rd;
    logic            w_wr_ok;
    logic            w_tx_hit;
    logic            w_status_hit;
    logic            w_cycle_hit;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic [31:0]     w_status;
    logic [31:0]     w_rdata;
    logic            w_unused;

    // Byte offset is carried by the lane enables, so address bits [1:0] are dropped.
    assign w_unused     = &{1'b0, bus.ram_addr[1:0]};

    assign w_word       = bus.ram_addr[31:2];
    assign w_ram_hit    = (bus.ram_addr[31:c_AW+2] == '0);
    assign w_ram_idx    = bus.ram_addr[c_AW+1:2];
    // Halt blocks the write that follows brk, not the one issued alongside it.
    assign w_wr_ok      = ~r_halted;
    assign w_ram_we     = {4{w_ram_hit & w_wr_ok}} & bus.ram_w;
    assign w_tx_hit     = (w_word == c_TXDATA_WORD);
    assign w_status_hit = (w_word == c_STATUS_WORD);
    assign w_cycle_hit  = (w_word == c_CYCLE_WORD);

    assign w_full       = (r_level == c_FULL_LEVEL);
    assign w_empty      = (r_level == '0);
    assign w_pop        = ~w_empty & bus.tx_ready;
    assign w_push_req   = w_tx_hit & bus.ram_w[0] & w_wr_ok;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push       = w_push_req & (~w_full | w_pop);
    assign w_ovf_set    = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr    = w_status_hit & (|bus.ram_w) & w_wr_ok;

    assign w_status     = {16'h0000, 8'(r_level), 5'b00000, r_ovf, w_empty, w_full};

    // One independent byte-wide memory per lane so each enable only touches its byte.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] r_mem [RAM_WORDS];

        // Lane write on the clock edge when this lane is enabled.
        always_ff @(posedge clk) begin
            if (w_ram_we[i]) begin
                r_mem[w_ram_idx] <= bus.ram_out[8*i +: 8];
            end
        end

        assign w_ram_rd[8*i +: 8] = r_mem[w_ram_idx];
    end

    // FIFO storage; contents need no reset because the level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.ram_out[7:0];
        end
    end

    // Control registers: halt latch, cycle counter, FIFO pointers/level, overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
            r_cycle  <= '0;
            r_ovf    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (bus.brk) begin
                r_halted <= 1'b1;
            end
            if (!r_halted) begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Zero-latency read mux; returns zero when no read is requested.
    always_comb begin
        w_rdata = '0;
        if (bus.ram_r) begin
            if (w_ram_hit) begin
                w_rdata = w_ram_rd;
            end else if (w_status_hit) begin
                w_rdata = w_status;
            end else if (w_cycle_hit) begin
                w_rdata = r_cycle;
            end
        end
    end

    assign bus.ram_in     = w_rdata;
    assign bus.halted     = r_halted;
    assign bus.tx_valid   = ~w_empty;
    assign bus.tx_data    = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign bus.fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_responder
// Description : Scoreboard bench for data_bus_responder. A behavioural model
//               (byte map, byte queue, counters) predicts every read and every
//               popped TX byte; a monitor compares them as the DUT shows them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_bus_responder;
    localparam int          RAM_WORDS = 1024;
    localparam int          DEPTH     = 8;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [31:0] TXA       = 32'h8000_0000;
    localparam logic [31:0] STA       = 32'h8000_0004;
    localparam logic [31:0] CYA       = 32'h8000_0008;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_bus_responder_if #(.FIFO_DEPTH(DEPTH)) bus ();

    data_bus_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_ram [int unsigned];
    logic [7:0]  m_fifo [$];
    bit          m_ovf;
    bit          m_halted;
    logic [31:0] m_cycle;

    // Scoreboards
    logic [31:0] exp_rd [$];
    logic [7:0]  exp_tx [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] wa;
        logic [31:0] v;
        wa = a & ~32'd3;
        v  = '0;
        if (wa < RAM_BYTES) begin
            for (int i = 0; i < 4; i++) v[8*i +: 8] = m_ram[wa + 32'(i)];
        end else if (wa == STA) begin
            v = (32'(m_fifo.size()) << 8) | (32'(m_ovf) << 2)
              | (32'(m_fifo.size() == 0) << 1) | 32'(m_fifo.size() == DEPTH);
        end else if (wa == CYA) begin
            v = m_cycle;
        end
        return v;
    endfunction

    task automatic model_edge(input logic [3:0] w, input logic [31:0] a,
                              input logic [31:0] d, input logic rdy, input logic b);
        logic [31:0] wa;
        wa = a & ~32'd3;
        if (!m_halted && wa < RAM_BYTES) begin
            for (int i = 0; i < 4; i++) if (w[i]) m_ram[wa + 32'(i)] = d[8*i +: 8];
        end
        if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (!m_halted && wa == TXA && w[0]) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        if (!m_halted && wa == STA && w != 4'h0) m_ovf = 1'b0;
        if (!m_halted) m_cycle = m_cycle + 32'd1;
        if (b) m_halted = 1'b1;
    endtask

    // One core cycle: drive at posedge+1, predict, check state mid-cycle, advance model at the edge.
    task automatic cyc(input logic r, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic b);
        bus.ram_r    = r;
        bus.ram_w    = w;
        bus.ram_addr = a;
        bus.ram_out  = d;
        bus.tx_ready = rdy;
        bus.brk      = b;
        if (r) exp_rd.push_back(model_read(a));
        if (rdy && m_fifo.size() > 0) exp_tx.push_back(m_fifo[0]);
        @(negedge clk);
        chk("fifo_level", 32'(bus.fifo_level), 32'(m_fifo.size()));
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_fifo.size() > 0));
        chk("tx_data", 32'(bus.tx_data), (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'h0);
        chk("halted", 32'(bus.halted), 32'(m_halted));
        @(posedge clk);
        model_edge(w, a, d, rdy, b);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 4'h0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    // Monitor: compare reads and accepted TX bytes whenever the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_r) begin
                if (exp_rd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected: got %h expected none", bus.ram_in);
                end else begin
                    chk("ram_in", bus.ram_in, exp_rd.pop_front());
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected: got %h expected none", bus.tx_data);
                end else begin
                    chk("tx_pop_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  w;
        logic        r, rdy;
        int unsigned op;

        bus.ram_r = 1'b0; bus.ram_w = 4'h0; bus.ram_addr = '0; bus.ram_out = '0;
        bus.tx_ready = 1'b0; bus.brk = 1'b0;
        m_ovf = 1'b0; m_halted = 1'b0; m_cycle = '0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst_level", 32'(bus.fifo_level), 32'h0);
        chk("rst_ram_in", bus.ram_in, 32'h0);
        rst = 1'b0;

        // Cycle counter starts at 1 after the first edge following release
        cyc(1'b1, 4'h0, CYA, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, CYA, 32'h0, 1'b0, 1'b0);

        // Fill a small RAM window so random reads hit defined bytes
        for (int i = 0; i < 16; i++) cyc(1'b0, 4'hF, 32'(4 * i), $urandom, 1'b0, 1'b0);

        // Lane merge: 0xDEADBEEF then lane 1 <- 0xAA gives 0xDEADAAEF
        cyc(1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cyc(1'b0, 4'h2, 32'h10, 32'h0000_AA00, 1'b0, 1'b0);
        bus.ram_r = 1'b1; bus.ram_w = 4'h0; bus.ram_addr = 32'h12; #1;
        chk("lane_merge_direct", bus.ram_in, 32'hDEAD_AAEF);
        cyc(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0);

        // Three bytes held, then drained in order; STATUS shows empty only
        cyc(1'b0, 4'h1, TXA, 32'h41, 1'b0, 1'b0);
        cyc(1'b0, 4'h1, TXA, 32'h42, 1'b0, 1'b0);
        cyc(1'b0, 4'h1, TXA, 32'h43, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        cyc(1'b1, 4'h0, STA, 32'h0, 1'b0, 1'b0);

        // Overflow: nine pushes into depth eight
        for (int i = 0; i < 9; i++) cyc(1'b0, 4'h1, TXA, 32'(8'h60 + i), 1'b0, 1'b0);
        chk("level_full", 32'(bus.fifo_level), 32'd8);
        cyc(1'b1, 4'h0, STA, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 4'h4, STA, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, STA, 32'h0, 1'b0, 1'b0);

        // Full FIFO: push and pop on the same edge keeps the level at 8, no overflow
        cyc(1'b0, 4'h1, TXA, 32'h99, 1'b1, 1'b0);
        chk("level_full_pushpop", 32'(bus.fifo_level), 32'd8);
        cyc(1'b1, 4'h0, STA, 32'h0, 1'b0, 1'b0);

        // Empty FIFO with ready high: push only
        for (int i = 0; i < 10; i++) idle(1'b1);
        cyc(1'b0, 4'h1, TXA, 32'h77, 1'b1, 1'b0);
        idle(1'b0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            op  = $urandom_range(0, 9);
            d   = $urandom;
            rdy = 1'($urandom_range(0, 1));
            r   = 1'b0;
            w   = 4'h0;
            case (op)
                0: begin a = $urandom_range(0, 63); r = 1'b1; end
                1: begin a = $urandom_range(0, 63); w = 4'($urandom_range(0, 15)); r = 1'($urandom_range(0, 1)); end
                2, 8, 9: begin a = TXA | 32'($urandom_range(0, 3)); w = 4'($urandom_range(0, 15)); end
                3: begin a = STA; r = 1'b1; end
                4: begin a = STA; w = 4'($urandom_range(0, 15)); r = 1'($urandom_range(0, 1)); end
                5: begin a = CYA | 32'($urandom_range(0, 3)); r = 1'b1; end
                6: begin a = CYA; w = 4'hF; r = 1'b1; end
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? (32'h1000 + 32'($urandom_range(0, 255))) : 32'h8000_000C;
                    w = 4'($urandom_range(0, 15));
                    r = 1'b1;
                end
            endcase
            cyc(r, w, a, d, rdy, 1'b0);
        end

        // Reset mid-drain with four bytes queued
        for (int i = 0; i < 12; i++) idle(1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'h1, TXA, 32'(8'hA0 + i), 1'b0, 1'b0);
        idle(1'b1);
        chk("pre_rst_level", 32'(bus.fifo_level), 32'd4);
        bus.ram_r = 1'b1; bus.ram_addr = CYA; bus.tx_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("arst_level", 32'(bus.fifo_level), 32'h0);
        chk("arst_cycle", bus.ram_in, 32'h0);
        m_fifo.delete(); m_ovf = 1'b0; m_halted = 1'b0; m_cycle = '0;
        bus.ram_r = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b1, 4'h0, CYA, 32'h0, 1'b0, 1'b0);

        // Halt: queue two bytes, brk with a same-cycle write that still commits
        cyc(1'b0, 4'h1, TXA, 32'h31, 1'b0, 1'b0);
        cyc(1'b0, 4'h1, TXA, 32'h32, 1'b0, 1'b0);
        cyc(1'b0, 4'hF, 32'h24, 32'hCAFE_F00D, 1'b0, 1'b1);
        cyc(1'b0, 4'hF, 32'h20, 32'h0000_1234, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 32'h24, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, CYA, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, CYA, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 4'h1, TXA, 32'h55, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("halt_sticky", 32'(bus.halted), 32'h1);
        chk("halt_drained", 32'(bus.fifo_level), 32'h0);

        chk("rd_scoreboard_empty", 32'(exp_rd.size()), 32'h0);
        chk("tx_scoreboard_empty", 32'(exp_tx.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
